mem_arbiter_n: RTL and testbench



---
 rtl/mem_arbiter_n.sv | 129 ++++++++++++
 tb/tb_mem_arbiter_n.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_n.sv
// N-channel arbiter in front of one synchronous single-port memory.
// One operation is in flight at a time: IDLE -> ISSUE -> (WAIT) -> COMPLETE.
module mem_arbiter_n #(
  parameter int NCH          = 3,
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int READ_LATENCY = 1,
  parameter int RR_MODE      = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          request,
  input  logic [NCH-1:0]          write,
  input  logic [NCH*(DW/8)-1:0]   byte_enable,
  input  logic [NCH*AW-1:0]       addr,
  input  logic [NCH*DW-1:0]       writedat,
  output logic [DW-1:0]           readdat,
  output logic [NCH-1:0]          done,
  output logic [AW-1:0]           memory_address,
  output logic                    memory_write_enable,
  output logic [DW/8-1:0]         memory_byte_enable,
  output logic [DW-1:0]           memory_write_data,
  input  logic [DW-1:0]           memory_read_data
);

  localparam int NBE = DW / 8;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMPLETE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_gnt;
  logic [IW-1:0]   r_ptr;
  logic            r_wr;
  logic [1:0]      r_cnt;
  logic [IW-1:0]   w_gnt;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic            w_wait_end;

  // Candidate channel for search slot i; round-robin starts just after the last grant.
  function automatic logic [IW-1:0] f_chan(input logic [IW-1:0] ptr, input int i);
    int k;
    k = (RR_MODE != 0) ? (int'(ptr) + 1 + i) % NCH : i;
    return IW'(k);
  endfunction

  always_comb begin
    w_gnt = '0;
    w_idx = '0;
    w_any = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      w_idx = f_chan(r_ptr, i);
      if (!w_any && request[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  // WAIT lasts READ_LATENCY cycles; data is captured on the last one.
  assign w_wait_end = (r_cnt == 2'(READ_LATENCY - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_any) w_state_nxt = ISSUE;
      ISSUE:    w_state_nxt = r_wr ? COMPLETE : WAIT;
      WAIT:     if (w_wait_end) w_state_nxt = COMPLETE;
      COMPLETE: w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt               <= '0;
      r_ptr               <= IW'(NCH - 1);
      r_wr                <= 1'b0;
      r_cnt               <= '0;
      readdat             <= '0;
      done                <= '0;
      memory_address      <= '0;
      memory_write_enable <= 1'b0;
      memory_byte_enable  <= '0;
      memory_write_data   <= '0;
    end else begin
      done                <= '0;
      memory_write_enable <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt          <= w_gnt;
            r_wr           <= write[w_gnt];
            r_cnt          <= '0;
            memory_address <= addr[w_gnt*AW +: AW];
            if (write[w_gnt]) begin
              // A zero lane mask still completes but must never strobe the memory.
              memory_write_enable <= |byte_enable[w_gnt*NBE +: NBE];
              memory_byte_enable  <= byte_enable[w_gnt*NBE +: NBE];
              memory_write_data   <= writedat[w_gnt*DW +: DW];
            end else begin
              memory_byte_enable  <= '1;
            end
            if (RR_MODE != 0) r_ptr <= w_gnt;
          end
        end
        ISSUE: begin
          if (r_wr) done[r_gnt] <= 1'b1;
        end
        WAIT: begin
          r_cnt <= r_cnt + 2'd1;
          if (w_wait_end) begin
            readdat     <= memory_read_data;
            done[r_gnt] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Bench for mem_arbiter_n: instance A (fixed priority, latency 1) and
// instance B (round-robin, latency 4), each with its own memory model.
module tb_mem_arbiter_n;

  logic clk = 1'b0;
  logic rst;
  logic preload;
  always #5 clk = ~clk;

  logic [2:0]  reqA, wrA, doneA, reqB, wrB, doneB;
  logic [5:0]  beA, beB;
  logic [47:0] addrA, wdA, addrB, wdB;
  logic [15:0] rdA, maA, mwdA, mrdA, rdB, maB, mwdB, mrdB;
  logic        weA, weB;
  logic [1:0]  mbeA, mbeB;

  mem_arbiter_n #(.NCH(3), .AW(16), .DW(16), .READ_LATENCY(1), .RR_MODE(0)) u_a (
    .clk(clk), .reset(rst), .request(reqA), .write(wrA), .byte_enable(beA),
    .addr(addrA), .writedat(wdA), .readdat(rdA), .done(doneA),
    .memory_address(maA), .memory_write_enable(weA), .memory_byte_enable(mbeA),
    .memory_write_data(mwdA), .memory_read_data(mrdA));

  mem_arbiter_n #(.NCH(3), .AW(16), .DW(16), .READ_LATENCY(4), .RR_MODE(1)) u_b (
    .clk(clk), .reset(rst), .request(reqB), .write(wrB), .byte_enable(beB),
    .addr(addrB), .writedat(wdB), .readdat(rdB), .done(doneB),
    .memory_address(maB), .memory_write_enable(weB), .memory_byte_enable(mbeB),
    .memory_write_data(mwdB), .memory_read_data(mrdB));

  // Synchronous memories: read data follows the address by the instance's latency.
  logic [15:0] memA [256];
  logic [15:0] memB [256];
  logic [15:0] pipA [4];
  logic [15:0] pipB [4];

  always @(posedge clk) begin
    if (preload) begin
      memA[8'h00] <= 16'h0000;
      memA[8'h10] <= 16'hBEEF;
      memA[8'h20] <= 16'h7700;
      memA[8'h30] <= 16'h0011;
    end else if (weA) begin
      if (mbeA[0]) memA[maA[7:0]][7:0]  <= mwdA[7:0];
      if (mbeA[1]) memA[maA[7:0]][15:8] <= mwdA[15:8];
    end
    pipA[0] <= memA[maA[7:0]];
    for (int i = 1; i < 4; i++) pipA[i] <= pipA[i-1];
  end

  always @(posedge clk) begin
    if (preload) begin
      memB[8'h00] <= 16'h5A5A;
      memB[8'h40] <= 16'h1357;
    end else if (weB) begin
      if (mbeB[0]) memB[maB[7:0]][7:0]  <= mwdB[7:0];
      if (mbeB[1]) memB[maB[7:0]][15:8] <= mwdB[15:8];
    end
    pipB[0] <= memB[maB[7:0]];
    for (int i = 1; i < 4; i++) pipB[i] <= pipB[i-1];
  end

  assign mrdA = pipA[0];
  assign mrdB = pipB[3];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    bit          b;
    int          ch;
    bit          wr;
    logic [1:0]  be;
    logic [15:0] a;
    logic [15:0] wd;
    logic [15:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vt[12];

  // Drive one request at a negedge and watch 12 cycles; returns with the DUT idle.
  task automatic run_op(input vec_t v, input int idx);
    int          k_done = 0, n_done = 0, n_we = 0, k_we = 0;
    bit          stray = 0;
    logic [15:0] rd_at = 16'h0, ma1 = 16'h0, mwd1 = 16'h0;
    logic [1:0]  mbe1 = 2'b00;
    logic [2:0]  d;
    logic        we;
    if (!v.b) begin
      wrA[v.ch] = v.wr; beA[v.ch*2 +: 2] = v.be;
      addrA[v.ch*16 +: 16] = v.a; wdA[v.ch*16 +: 16] = v.wd;
      reqA = 3'b001 << v.ch;
    end else begin
      wrB[v.ch] = v.wr; beB[v.ch*2 +: 2] = v.be;
      addrB[v.ch*16 +: 16] = v.a; wdB[v.ch*16 +: 16] = v.wd;
      reqB = 3'b001 << v.ch;
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      d  = v.b ? doneB : doneA;
      we = v.b ? weB : weA;
      if (k == 1) begin
        ma1  = v.b ? maB : maA;
        mbe1 = v.b ? mbeB : mbeA;
        mwd1 = v.b ? mwdB : mwdA;
      end
      if (we) begin n_we++; k_we = k; end
      if ((d & ~(3'b001 << v.ch)) != 3'b000) stray = 1'b1;
      if (d[v.ch]) begin
        n_done++;
        if (k_done == 0) begin
          k_done = k;
          rd_at  = v.b ? rdB : rdA;
        end
        if (v.b) reqB = 3'b000; else reqA = 3'b000;
      end
    end
    chk($sformatf("v%0d latency", idx), k_done, v.exp_lat);
    chk($sformatf("v%0d readdat", idx), rd_at, v.exp_rd);
    chk($sformatf("v%0d done pulses", idx), n_done, 1);
    chk($sformatf("v%0d stray done", idx), stray, 0);
    chk($sformatf("v%0d addr at issue", idx), ma1, v.a);
    chk($sformatf("v%0d lanes at issue", idx), mbe1, v.wr ? v.be : 2'b11);
    chk($sformatf("v%0d we count", idx), n_we, (v.wr && v.be != 2'b00) ? 1 : 0);
    if (n_we != 0) chk($sformatf("v%0d we cycle", idx), k_we, 1);
    if (v.wr) chk($sformatf("v%0d wdata at issue", idx), mwd1, v.wd);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  int   order[$];
  int   cnt0;
  int   k_last;
  int   n_stray;
  logic [15:0] rd_last;
  int   exp_prio[6] = '{0, 0, 0, 0, 1, 2};

  initial begin
    rst = 1'b1; preload = 1'b1;
    reqA = '0; wrA = '0; beA = '0; addrA = '0; wdA = '0;
    reqB = '0; wrB = '0; beB = '0; addrB = '0; wdB = '0;

    vt[0]  = '{1'b0, 1, 1'b0, 2'b11, 16'h0010, 16'h0000, 16'hBEEF, 3};
    vt[1]  = '{1'b0, 2, 1'b1, 2'b01, 16'h0020, 16'h12AB, 16'hBEEF, 2};
    vt[2]  = '{1'b0, 0, 1'b0, 2'b11, 16'h0020, 16'h0000, 16'h77AB, 3};
    vt[3]  = '{1'b0, 0, 1'b1, 2'b11, 16'h0000, 16'h5A5A, 16'h77AB, 2};
    vt[4]  = '{1'b0, 2, 1'b0, 2'b11, 16'h0000, 16'h0000, 16'h5A5A, 3};
    vt[5]  = '{1'b0, 1, 1'b1, 2'b00, 16'h0000, 16'hFFFF, 16'h5A5A, 2};
    vt[6]  = '{1'b0, 1, 1'b0, 2'b11, 16'h0000, 16'h0000, 16'h5A5A, 3};
    vt[7]  = '{1'b0, 2, 1'b1, 2'b10, 16'h0030, 16'hC3D4, 16'h5A5A, 2};
    vt[8]  = '{1'b0, 0, 1'b0, 2'b11, 16'h0030, 16'h0000, 16'hC311, 3};
    vt[9]  = '{1'b1, 0, 1'b0, 2'b11, 16'h0000, 16'h0000, 16'h5A5A, 6};
    vt[10] = '{1'b1, 2, 1'b1, 2'b00, 16'h0000, 16'h1234, 16'h5A5A, 2};
    vt[11] = '{1'b1, 1, 1'b0, 2'b11, 16'h0040, 16'h0000, 16'h1357, 6};

    repeat (2) @(negedge clk);
    chk("reset A done", doneA, 0);
    chk("reset A readdat", rdA, 0);
    chk("reset A addr", maA, 0);
    chk("reset A we", weA, 0);
    chk("reset A lanes", mbeA, 0);
    chk("reset A wdata", mwdA, 0);
    chk("reset B done", doneB, 0);
    chk("reset B addr", maB, 0);
    preload = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_op(vt[i], i);

    // Fixed priority: ch0 starves ch1/ch2 until it stops asking.
    wrA = 3'b000;
    addrA = {16'h0030, 16'h0020, 16'h0010};
    reqA = 3'b111;
    cnt0 = 0; n_stray = 0; k_last = 0; rd_last = 16'h0;
    order.delete();
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if ($countones(doneA) > 1) n_stray++;
      else if (doneA != 3'b000) order.push_back(doneA[0] ? 0 : (doneA[1] ? 1 : 2));
      if (doneA[0]) begin cnt0++; if (cnt0 == 4) reqA[0] = 1'b0; end
      if (doneA[1]) reqA[1] = 1'b0;
      if (doneA[2]) begin reqA[2] = 1'b0; k_last = k; rd_last = rdA; end
    end
    chk("prio done count", order.size(), 6);
    chk("prio multi done", n_stray, 0);
    for (int i = 0; i < order.size() && i < 6; i++)
      chk($sformatf("prio order %0d", i), order[i], exp_prio[i]);
    chk("prio ch2 done cycle", k_last, 23);
    chk("prio ch2 readdat", rd_last, 16'hC311);

    // Round-robin: after reset the pointer favours ch0, then rotates.
    pulse_reset();
    wrB = 3'b000;
    addrB = {16'h0000, 16'h0040, 16'h0000};
    reqB = 3'b111;
    n_stray = 0; k_last = 0;
    order.delete();
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if ($countones(doneB) > 1) n_stray++;
      else if (doneB != 3'b000) begin
        order.push_back(doneB[0] ? 0 : (doneB[1] ? 1 : 2));
        if (order.size() == 6) begin reqB = 3'b000; k_last = k; end
      end
    end
    chk("rr done count", order.size(), 6);
    chk("rr multi done", n_stray, 0);
    for (int i = 0; i < order.size() && i < 6; i++)
      chk($sformatf("rr order %0d", i), order[i], i % 3);
    chk("rr sixth done cycle", k_last, 41);

    // Reset in the middle of a latency-4 read abandons it without a done.
    addrB[15:0] = 16'h0040; wrB[0] = 1'b0;
    reqB = 3'b001;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    reqB = 3'b000;
    #1;
    chk("midrst done", doneB, 0);
    chk("midrst readdat", rdB, 0);
    chk("midrst addr", maB, 0);
    chk("midrst lanes", mbeB, 0);
    chk("midrst wdata", mwdB, 0);
    @(negedge clk);
    rst = 1'b0;
    n_stray = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (doneB != 3'b000) n_stray++;
    end
    chk("midrst no done", n_stray, 0);
    run_op('{1'b1, 1, 1'b0, 2'b11, 16'h0040, 16'h0000, 16'h1357, 6}, 12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
